// File: rtl/ldpc_slot_arbiter.sv
// Purpose: shares one LDPC decoder among NUM_SLOTS soft-LLR packet streams.
//   It uses packet-level round-robin on the decoder input and a grant-order FIFO
//   to route decoded packets back to their source slots.
// Latency: input and output datapaths are zero-latency combinational muxes.
//   Each packet costs one extra IDLE arbitration cycle.
// Backpressure: the granted slot sees dec_in_ready, and the head-of-FIFO slot drives
//   dec_out_ready. Arbitration stalls while ORDER_DEPTH codewords are in flight.
// Ports:
//   clk_clk, reset_reset_n            : clock, asynchronous active-low reset
//   req_valid/ready/sop/eop/data      : per-slot LLR input streams (slot k at [k*LLR_W +: LLR_W])
//   dec_in_valid/ready/sop/eop/data   : decoder Avalon-ST input
//   dec_out_valid/ready/sop/eop/data  : decoder Avalon-ST output
//   rsp_valid/ready/sop/eop/data      : per-slot decoded streams (data broadcast to all slots)
//   in_flight                         : codewords granted but not yet fully returned
//   proto_err                         : sticky, set on a non-sop beat offered while IDLE
module ldpc_slot_arbiter #(
  parameter int NUM_SLOTS   = 4,
  parameter int ORDER_DEPTH = 4,
  parameter int LLR_W       = 6,
  parameter int OUT_W       = 2
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic [NUM_SLOTS-1:0]           req_valid,
  output logic [NUM_SLOTS-1:0]           req_ready,
  input  logic [NUM_SLOTS-1:0]           req_sop,
  input  logic [NUM_SLOTS-1:0]           req_eop,
  input  logic [NUM_SLOTS*LLR_W-1:0]     req_data,
  output logic                           dec_in_valid,
  output logic                           dec_in_sop,
  output logic                           dec_in_eop,
  output logic [LLR_W-1:0]               dec_in_data,
  input  logic                           dec_in_ready,
  input  logic                           dec_out_valid,
  input  logic                           dec_out_sop,
  input  logic                           dec_out_eop,
  input  logic [OUT_W-1:0]               dec_out_data,
  output logic                           dec_out_ready,
  output logic [NUM_SLOTS-1:0]           rsp_valid,
  output logic [NUM_SLOTS-1:0]           rsp_sop,
  output logic [NUM_SLOTS-1:0]           rsp_eop,
  output logic [NUM_SLOTS*OUT_W-1:0]     rsp_data,
  input  logic [NUM_SLOTS-1:0]           rsp_ready,
  output logic [$clog2(ORDER_DEPTH):0]   in_flight,
  output logic                           proto_err
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int AW = $clog2(ORDER_DEPTH);

  typedef logic [SW-1:0] slot_t;
  typedef enum logic {IDLE, XFER} state_t;

  state_t  state_q, state_d;
  slot_t   grant_q, grant_d;
  slot_t   rr_ptr_q, rr_ptr_d;
  logic    err_set;

  // Arbitration result
  logic    pick_vld;
  slot_t   pick;

  // Grant-order FIFO: one slot id per codeword inside the decoder
  slot_t            order_mem [ORDER_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             fifo_full, fifo_empty, push, pop;
  slot_t            head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(ORDER_DEPTH));
  assign head       = order_mem[rd_ptr_q];
  assign in_flight  = count_q;

  // Round-robin search starting one past the last granted slot
  always_comb begin
    slot_t idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      idx = slot_t'((int'(rr_ptr_q) + i) % NUM_SLOTS);
      if (!pick_vld && req_valid[idx] && req_sop[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // Input FSM: next state and input-side outputs
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    req_ready    = '0;
    dec_in_valid = 1'b0;
    dec_in_sop   = 1'b0;
    dec_in_eop   = 1'b0;
    dec_in_data  = '0;
    push         = 1'b0;
    err_set      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Stray mid-packet beats are swallowed so they cannot wedge a slot.
        // They are blocked while reset is held so that all ready outputs stay low.
        if (reset_reset_n) begin
          req_ready = req_valid & ~req_sop;
        end
        err_set = |(req_valid & ~req_sop);
        if (pick_vld && !fifo_full) begin
          grant_d = pick;
          push    = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        dec_in_valid       = req_valid[grant_q];
        dec_in_sop         = req_sop[grant_q];
        dec_in_eop         = req_eop[grant_q];
        dec_in_data        = req_data[int'(grant_q)*LLR_W +: LLR_W];
        req_ready[grant_q] = dec_in_ready;
        if (req_valid[grant_q] && dec_in_ready && req_eop[grant_q]) begin
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output routing to the slot at the FIFO head
  always_comb begin
    rsp_valid     = '0;
    rsp_sop       = '0;
    rsp_eop       = '0;
    dec_out_ready = 1'b0;
    if (!fifo_empty) begin
      rsp_valid[head] = dec_out_valid;
      rsp_sop[head]   = dec_out_sop;
      rsp_eop[head]   = dec_out_eop;
      dec_out_ready   = rsp_ready[head];
    end
  end

  assign pop      = !fifo_empty && dec_out_valid && rsp_ready[head] && dec_out_eop;
  assign rsp_data = {NUM_SLOTS{dec_out_data}};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= slot_t'(NUM_SLOTS-1);
      proto_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (err_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < ORDER_DEPTH; i++) begin
        order_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        order_mem[wr_ptr_q] <= grant_d;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
